// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: word-addressed 32-bit store with fixed read latency and a load port.
// Optional address range checking is enabled by defining INST_MEM_BOUNDS_CHK_EN.
module inst_mem_resp #(
    parameter int          DEPTH     = 1024,
    parameter int          AW        = 10,
    parameter int          LATENCY   = 1,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_ena,
    input  logic [63:0]   inst_addr,
    output logic          inst_ready,
    output logic [31:0]   inst,
    output logic          inst_valid,
    output logic          inst_err,
    input  logic          ld_ena,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data
);

    localparam int          CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd4;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [63:0]    addr_q, addr_d;
    logic [31:0]    inst_q;
    logic           err_q;
    logic [31:0]    mem_q [DEPTH];

    logic           accept;
    logic           rsp_load;
    logic [63:0]    rsp_addr;
    logic [AW-1:0]  rsp_idx;
    logic           rsp_fault;

    assign inst_ready = rst && (state_q != BUSY);
    assign accept     = inst_ena && inst_ready;
    assign inst_valid = (state_q == RESP);
    assign inst       = inst_q;
    assign inst_err   = err_q;

    // With LATENCY==1 the read happens on the accept edge, so the live address is used.
    assign rsp_addr = (state_q == BUSY) ? addr_q : inst_addr;
    assign rsp_idx  = AW'((rsp_addr - BASE_ADDR) >> 2);

`ifdef INST_MEM_BOUNDS_CHK_EN
    assign rsp_fault = (rsp_addr[1:0] != 2'b00) || (rsp_addr < BASE_ADDR)
                     || ((rsp_addr - BASE_ADDR) >= SPAN);
`else
    assign rsp_fault = (rsp_addr[1:0] != 2'b00);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        rsp_load = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    addr_d = inst_addr;
                    if (LATENCY == 1) begin
                        state_d  = RESP;
                        rsp_load = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = RESP;
                    rsp_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            inst_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            if (rsp_load) begin
                if (rsp_fault) begin
                    inst_q <= NOP;
                    err_q  <= 1'b1;
                end else begin
                    inst_q <= mem_q[rsp_idx];
                    err_q  <= 1'b0;
                end
            end
        end
    end

    // Store is never cleared; a same-edge write is seen only by later reads.
    always_ff @(posedge clk) begin
        if (ld_ena && rst) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

endmodule

// File: tb/tb_inst_mem_resp.sv
// Randomized bench for inst_mem_resp: two instances (LATENCY 1 and 3) share stimulus and are
// checked every cycle against a request-level reference model.
module tb_inst_mem_resp;

    localparam int          DEPTH = 1024;
    localparam int          AW    = 10;
    localparam logic [63:0] BASE  = 64'h0;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_ena;
    logic [63:0]   inst_addr;
    logic          ld_ena;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;

    logic          ready_w [2];
    logic          valid_w [2];
    logic          err_w   [2];
    logic [31:0]   inst_w  [2];

    always #5 clk = ~clk;

    inst_mem_resp #(.DEPTH(DEPTH), .AW(AW), .LATENCY(1), .BASE_ADDR(BASE)) u_dut_l1 (
        .clk(clk), .rst(rst), .inst_ena(inst_ena), .inst_addr(inst_addr),
        .inst_ready(ready_w[0]), .inst(inst_w[0]), .inst_valid(valid_w[0]), .inst_err(err_w[0]),
        .ld_ena(ld_ena), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    inst_mem_resp #(.DEPTH(DEPTH), .AW(AW), .LATENCY(3), .BASE_ADDR(BASE)) u_dut_l3 (
        .clk(clk), .rst(rst), .inst_ena(inst_ena), .inst_addr(inst_addr),
        .inst_ready(ready_w[1]), .inst(inst_w[1]), .inst_valid(valid_w[1]), .inst_err(err_w[1]),
        .ld_ena(ld_ena), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    // Reference model state
    int          lat [2] = '{1, 3};
    logic [31:0] mmem [DEPTH];
    bit          pend [2];
    int          left [2];
    logic [63:0] paddr [2];
    bit          exp_valid [2];
    logic [31:0] exp_inst [2];
    bit          exp_err [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic respond(input int d, input logic [63:0] a);
        bit bad;
        bad = (a[1:0] != 2'b00);
`ifdef INST_MEM_BOUNDS_CHK_EN
        if (a < BASE || (a - BASE) >= 64'(DEPTH) * 4) bad = 1'b1;
`endif
        exp_valid[d] = 1'b1;
        if (bad) begin
            exp_inst[d] = NOP;
            exp_err[d]  = 1'b1;
        end else begin
            exp_inst[d] = mmem[int'(((a - BASE) >> 2) % 64'(DEPTH))];
            exp_err[d]  = 1'b0;
        end
    endtask

    // Applies the rules for the coming edge using the inputs currently driven.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            exp_valid[d] = 1'b0;
            if (!rst) begin
                pend[d]     = 1'b0;
                left[d]     = 0;
                exp_inst[d] = 32'h0;
                exp_err[d]  = 1'b0;
            end else if (pend[d]) begin
                left[d]--;
                if (left[d] == 0) begin
                    pend[d] = 1'b0;
                    respond(d, paddr[d]);
                end
            end else if (inst_ena) begin
                paddr[d] = inst_addr;
                if (lat[d] == 1) respond(d, inst_addr);
                else begin
                    pend[d] = 1'b1;
                    left[d] = lat[d] - 1;
                end
            end
        end
        if (ld_ena && rst) mmem[ld_addr] = ld_data;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("valid_l%0d", lat[d]), 64'(valid_w[d]), 64'(exp_valid[d]));
            chk($sformatf("ready_l%0d", lat[d]), 64'(ready_w[d]), 64'(rst && !pend[d]));
            chk($sformatf("inst_l%0d", lat[d]), 64'(inst_w[d]), 64'(exp_inst[d]));
            chk($sformatf("err_l%0d", lat[d]), 64'(err_w[d]), 64'(exp_err[d]));
        end
    endtask

    task automatic drive(input bit r, input bit e, input logic [63:0] a,
                         input bit l, input int la, input logic [31:0] ld);
        rst       = r;
        inst_ena  = e;
        inst_addr = a;
        ld_ena    = l;
        ld_addr   = AW'(la);
        ld_data   = ld;
        $display("cyc rst=%0b ena=%0b addr=%h ld=%0b ld_addr=%0d ld_data=%h",
                 r, e, a, l, la, ld);
        cyc();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 64'h0, 1'b0, 0, 32'h0);
    endtask

    logic [31:0] t2 [4] = '{32'h13, 32'h93, 32'h113, 32'h193};

    initial begin
        logic [63:0] a;
        int r;
        @(negedge clk);
        // Reset held for two cycles, then release
        drive(1'b0, 1'b0, 64'h0, 1'b0, 0, 32'h0);
        drive(1'b0, 1'b1, 64'h0, 1'b1, 0, 32'h0);
        // Preload the whole store so every fetch has a defined value
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 64'h0, 1'b1, i, $urandom);
        // Back-to-back fetches
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 64'h0, 1'b1, i, t2[i]);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 64'(i * 4), 1'b0, 0, 32'h0);
        idle(4);
        // Single request, then a request held across the busy window
        drive(1'b1, 1'b0, 64'h0, 1'b1, 1, 32'hDEAD_BEEF);
        drive(1'b1, 1'b1, 64'h4, 1'b0, 0, 32'h0);
        idle(4);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 64'h4, 1'b0, 0, 32'h0);
        idle(4);
        // Misaligned fetch
        drive(1'b1, 1'b1, 64'h6, 1'b0, 0, 32'h0);
        idle(4);
        // Write/read collision on word 2, then re-fetch
        drive(1'b1, 1'b0, 64'h0, 1'b1, 2, 32'h5555);
        drive(1'b1, 1'b1, 64'h8, 1'b1, 2, 32'hAAAA);
        idle(4);
        drive(1'b1, 1'b1, 64'h8, 1'b0, 0, 32'h0);
        idle(4);
        // Beyond the store
        drive(1'b1, 1'b1, 64'h1000, 1'b0, 0, 32'h0);
        idle(4);
        // Reset while a request is in flight
        drive(1'b1, 1'b1, 64'h0, 1'b0, 0, 32'h0);
        drive(1'b0, 1'b0, 64'h0, 1'b0, 0, 32'h0);
        idle(4);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      a = 64'($urandom_range(0, DEPTH - 1)) << 2;
            else if (r < 8) a = 64'($urandom_range(0, 4 * DEPTH - 1));
            else            a = {32'($urandom_range(0, 3)), 32'($urandom)};
            drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7), a,
                  ($urandom_range(0, 4) == 0), $urandom_range(0, DEPTH - 1), $urandom);
        end
        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
